// File: rtl/pkt_fifo.sv
// pkt_fifo: packet-aware first-word-fall-through FIFO with occupancy and packet status.
// Define PKT_DROP_EN for store-and-forward with bad/oversize packet discard; otherwise cut-through.
module pkt_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  input  logic                  s_err,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH:0]   pkt_count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  drop
);
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] ZERO_P   = {PW{1'b0}};
  localparam logic [PW-1:0] ONE_P    = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] DEPTH_P  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0] AFULL_P  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_P = PW'(AEMPTY_THRESH);

  logic [DATA_WIDTH:0] mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]       pkt_count_q, pkt_count_d;
  logic [PW-1:0]       commit_ptr_s, count_s, occ_s;
  logic [DATA_WIDTH:0] rd_word_s;
  logic                wr_hs_s, rd_hs_s, rd_last_s, mem_we_s, commit_s, full_s;

  assign count_s      = wr_ptr_q - rd_ptr_q;
  assign occ_s        = commit_ptr_s - rd_ptr_q;
  assign full_s       = (count_s == DEPTH_P);
  assign rd_word_s    = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
  assign m_valid      = (occ_s != ZERO_P);
  assign m_data       = rd_word_s[DATA_WIDTH-1:0];
  assign m_last       = rd_word_s[DATA_WIDTH];
  assign rd_hs_s      = m_valid & m_ready;
  assign rd_last_s    = rd_hs_s & m_last;
  assign wr_hs_s      = s_valid & s_ready;
  assign count        = count_s;
  assign pkt_count    = pkt_count_q;
  assign almost_full  = (count_s >= AFULL_P);
  assign almost_empty = (occ_s <= AEMPTY_P);

`ifdef PKT_DROP_EN
  typedef enum logic [0:0] {
    ST_ACCEPT  = 1'b0,
    ST_DISCARD = 1'b1
  } wr_state_e;

  wr_state_e     state_q, state_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic          drop_q, drop_d;
  logic          stuck_s;

  // An open packet occupying every entry can never complete, so it must be abandoned.
  assign stuck_s      = full_s & (commit_ptr_q == rd_ptr_q);
  assign commit_ptr_s = commit_ptr_q;
  assign s_ready      = ~rst & ((state_q == ST_DISCARD) | ~full_s);
  assign drop         = drop_q;

  // Write FSM next-state: store, commit, rewind on error, or swallow an oversize tail.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    mem_we_s     = 1'b0;
    commit_s     = 1'b0;
    drop_d       = 1'b0;
    case (state_q)
      ST_ACCEPT: begin
        if (stuck_s) begin
          state_d  = ST_DISCARD;
          wr_ptr_d = commit_ptr_q;
          drop_d   = 1'b1;
        end else if (wr_hs_s && s_last && s_err) begin
          wr_ptr_d = commit_ptr_q;
          drop_d   = 1'b1;
        end else if (wr_hs_s) begin
          mem_we_s = 1'b1;
          wr_ptr_d = wr_ptr_q + ONE_P;
          if (s_last) begin
            commit_ptr_d = wr_ptr_q + ONE_P;
            commit_s     = 1'b1;
          end else begin
            commit_ptr_d = commit_ptr_q;
          end
        end else begin
          state_d = ST_ACCEPT;
        end
      end
      ST_DISCARD: begin
        if (wr_hs_s && s_last) begin
          state_d = ST_ACCEPT;
        end else begin
          state_d = ST_DISCARD;
        end
      end
      default: begin
        state_d = ST_ACCEPT;
      end
    endcase
  end

  // Write FSM, commit pointer and drop pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ACCEPT;
      commit_ptr_q <= ZERO_P;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      commit_ptr_q <= commit_ptr_d;
      drop_q       <= drop_d;
    end
  end
`else
  logic unused_s;

  assign unused_s     = s_err;
  assign commit_ptr_s = wr_ptr_q;
  assign s_ready      = ~rst & ~full_s;
  assign drop         = 1'b0;

  // Cut-through write: every accepted beat is stored and immediately readable.
  always_comb begin
    mem_we_s = wr_hs_s;
    commit_s = wr_hs_s & s_last;
    if (wr_hs_s) begin
      wr_ptr_d = wr_ptr_q + ONE_P;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
  end
`endif

  // Read pointer advance and packet count; a commit and a last-beat read cancel out.
  always_comb begin
    if (rd_hs_s) begin
      rd_ptr_d = rd_ptr_q + ONE_P;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({commit_s, rd_last_s})
      2'b10:   pkt_count_d = pkt_count_q + ONE_P;
      2'b01:   pkt_count_d = pkt_count_q - ONE_P;
      default: pkt_count_d = pkt_count_q;
    endcase
  end

  // Beat storage: payload plus last flag; contents need no reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= {s_last, s_data};
    end
  end

  // Pointer and packet count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= ZERO_P;
      rd_ptr_q    <= ZERO_P;
      pkt_count_q <= ZERO_P;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_count_q <= pkt_count_d;
    end
  end
endmodule
